relay_1553: RTL and testbench
=============================

// Module: relay_1553
// PURPOSE
//  Parametrised N-channel 1553 word relay. Captures decoded words (CSW/DW) from NUM_CH
//  decoder cores into per-channel FIFOs, arbitrates without splitting messages, and
//  drives one encoder via a request/busy handshake with an enforced inter-word gap.
//  Successor to the hard-wired BC->encoder pulse-stretch path; sits between the
//  core_1553 instances and encoder_1553, all on one clock domain.
// PARAMETERS
//  NUM_CH       2    number of receive channels (1..8)
//  FIFO_DEPTH   8    words per channel FIFO (power of 2, >=2)
//  GAP_CYCLES   8    idle clk cycles after tx_busy falls before the next request
//  REQ_TIMEOUT  64   clk cycles in REQ without tx_busy before the word is abandoned
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            asynchronous reset, active low
//  ch_enable    in   NUM_CH       per-channel capture enable
//  drop_perr    in   1            1: discard words flagged rx_perr
//  rx_dval      in   NUM_CH       one-cycle word-valid pulse per channel
//  rx_csw       in   NUM_CH       word is command/status
//  rx_dw        in   NUM_CH       word is data
//  rx_perr      in   NUM_CH       parity error on word
//  rx_dword     in   16*NUM_CH    word payload, ch c at [16c+15:16c]
//  tx_busy      in   1            encoder busy
//  tx_dword     out  16           word to encoder, stable while tx_csw|tx_dw
//  tx_csw       out  1            request CSW transmit (level, held through REQ)
//  tx_dw        out  1            request DW transmit (level, held through REQ)
//  tx_ch        out  $clog2(NUM_CH) (min 1)  source channel of current word
//  ovf_flag     out  NUM_CH       sticky FIFO-overflow flag per channel
//  ovf_clr      in   1            clears all ovf_flag bits
//  err_cnt      out  8            saturating count of dropped/illegal/timed-out words
//  word_cnt     out  16           wrapping count of words handed to encoder
// BEHAVIOUR
//  - Reset: all FIFOs empty, FSM IDLE, tx_csw/tx_dw=0, tx_dword=0, tx_ch=0, ovf_flag=0,
//    err_cnt=0, word_cnt=0, arbiter pointer=0. Reset mid-REQ/BUSY drops the word.
//  - Capture: on rx_dval[c] & ch_enable[c] push {csw,dw,dword}. Not pushed, err_cnt+1:
//    csw==dw (both or neither); rx_perr & drop_perr. Disabled channel: ignored, no count.
//  - FIFO full: push dropped, ovf_flag[c]<=1, err_cnt+1; push with same-cycle pop on a
//    full FIFO is accepted. ovf_clr and a new overflow in same cycle: flag stays set.
//  - err_cnt saturates at 255; word_cnt wraps 16'hFFFF->0.
//  - FSM IDLE->REQ: any enabled non-empty FIFO. Grant = round-robin from last_ch+1,
//    except LOCK: if last word sent was from ch L and L's head is a DW, L is granted.
//    Pop head at grant; tx_dword/tx_ch load, tx_csw or tx_dw asserts next cycle.
//  - Latency: rx_dval at cycle N into empty idle relay -> request high at N+2.
//  - REQ->BUSY on tx_busy=1: drop request same edge, word_cnt+1. REQ timeout after
//    REQ_TIMEOUT cycles: drop request, err_cnt+1, ->GAP.
//  - BUSY->GAP on tx_busy=0; GAP counts GAP_CYCLES then ->IDLE. GAP_CYCLES=0: GAP
//    lasts one cycle. tx_dword holds last value until next grant.
//  - ch_enable fall: captured words remain and are transmitted; no flush.
// STRUCTURE
//  - pkg_1553: WORD_W=16, ENTRY_W=18 ({csw,dw,dword}), FSM state encoding
//    (IDLE/REQ/BUSY/GAP), err_cnt width.
//  - sub-module fifo_1553 (sync FIFO, DEPTH param, full/empty, push/pop same cycle),
//    instantiated NUM_CH times by generate; arbiter, FSM, counters in relay_1553.
// TESTING
//  - Single CSW 16'h0C21 on ch0, tx_busy 1 cycle after request for 40 cycles ->
//    tx_csw high at N+2, tx_dword=0C21, tx_ch=0, word_cnt=1, err_cnt=0.
//  - ch0 CSW+3 DW, ch1 CSW queued during ch0 message -> order ch0 CSW,DW,DW,DW then ch1.
//  - FIFO_DEPTH=8, tx_busy stuck 1, push 10 words on ch1 -> 8 held, ovf_flag=2'b10,
//    err_cnt=2; ovf_clr -> 0; drain delivers first 8 words in order.
//  - rx_dval with csw=dw=1, and perr word with drop_perr=1 -> nothing queued, err_cnt=2.
//  - tx_busy never rises -> request drops after 64 cycles, err_cnt=1, next word sent.
//  - reset_n low during BUSY -> outputs at reset values, FIFOs empty, no stale request.

Source files
------------

// File: rtl/relay_1553_pkg.sv
// relay_1553_pkg: shared widths, FIFO entry layout and FSM encoding for the 1553 word relay
package relay_1553_pkg;
  localparam int WORD_W = 16;
  localparam int ENTRY_W = WORD_W + 2;
  localparam int ERR_W = 8;
  typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} state_t;
  typedef struct packed {
    logic              csw;
    logic              dw;
    logic [WORD_W-1:0] dword;
  } entry_t;
endpackage

// File: rtl/relay_1553_fifo.sv
// relay_1553_fifo: synchronous per-channel word FIFO; a push alongside a pop is accepted even when full
module relay_1553_fifo
  import relay_1553_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/relay_1553.sv
// relay_1553: N-channel 1553 word relay; per-channel FIFOs, message-preserving round-robin
// arbitration and a request/busy handshake to one encoder with an enforced inter-word gap
module relay_1553
  import relay_1553_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_CYCLES  = 8,
  parameter int REQ_TIMEOUT = 64,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     drop_perr,
  input  logic [NUM_CH-1:0]        rx_dval,
  input  logic [NUM_CH-1:0]        rx_csw,
  input  logic [NUM_CH-1:0]        rx_dw,
  input  logic [NUM_CH-1:0]        rx_perr,
  input  logic [WORD_W*NUM_CH-1:0] rx_dword,
  input  logic                     tx_busy,
  output logic [WORD_W-1:0]        tx_dword,
  output logic                     tx_csw,
  output logic                     tx_dw,
  output logic [CH_W-1:0]          tx_ch,
  output logic [NUM_CH-1:0]        ovf_flag,
  input  logic                     ovf_clr,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [15:0]              word_cnt
);
  localparam int TMR_MAX = REQ_TIMEOUT > GAP_CYCLES ? REQ_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int GAP_LEN = GAP_CYCLES > 0 ? GAP_CYCLES : 1;
  state_t            state, state_nx;
  entry_t            head [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, pop, ev, ovf;
  logic [CH_W-1:0]   rr_ptr, grant, idx;
  logic              any, lock, last_vld, cur_csw, tmo, gap_done;
  logic [TMR_W-1:0]  tmr;
  logic [3:0]        n_err;
  logic [ERR_W:0]    err_sum;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic take, illegal;
    assign take    = rx_dval[c] & ch_enable[c];
    assign illegal = (rx_csw[c] == rx_dw[c]) | (rx_perr[c] & drop_perr);
    assign push[c] = take & ~illegal;
    assign ovf[c]  = push[c] & full[c] & ~pop[c];
    assign ev[c]   = (take & illegal) | ovf[c];
    relay_1553_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[c]),
      .pop     (pop[c]),
      .din     ({rx_csw[c], rx_dw[c], rx_dword[WORD_W*c +: WORD_W]}),
      .dout    (head[c]),
      .full    (full[c]),
      .empty   (empty[c])
    );
  end
  // Scan downwards so the channel closest after rr_ptr wins; a pending DW on the last
  // channel keeps the message together.
  always_comb begin
    idx   = '0;
    grant = rr_ptr;
    any   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!empty[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
    lock  = last_vld & ~empty[tx_ch] & head[tx_ch].dw;
    grant = lock ? tx_ch : grant;
  end
  assign pop      = (state == IDLE && any) ? NUM_CH'(1) << grant : '0;
  assign tmo      = state == REQ && !tx_busy && tmr == TMR_W'(REQ_TIMEOUT - 1);
  assign gap_done = tmr == TMR_W'(GAP_LEN - 1);
  always_comb begin
    n_err = {3'b0, tmo};
    for (int i = 0; i < NUM_CH; i++) n_err = n_err + {3'b0, ev[i]};
    err_sum = {1'b0, err_cnt} + {{(ERR_W-3){1'b0}}, n_err};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any ? REQ : IDLE;
      REQ:     state_nx = tx_busy ? BUSY : (tmo ? GAP : REQ);
      BUSY:    state_nx = tx_busy ? BUSY : GAP;
      GAP:     state_nx = gap_done ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  assign tx_csw = state == REQ && cur_csw;
  assign tx_dw  = state == REQ && !cur_csw;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_dword <= '0;
      tx_ch    <= '0;
      cur_csw  <= 1'b0;
      last_vld <= 1'b0;
      rr_ptr   <= '0;
      tmr      <= '0;
      err_cnt  <= '0;
      word_cnt <= '0;
      ovf_flag <= '0;
    end else begin
      if (state == IDLE && any) begin
        tx_dword <= head[grant].dword;
        tx_ch    <= grant;
        cur_csw  <= head[grant].csw;
        last_vld <= 1'b1;
        rr_ptr   <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
      tmr      <= (state_nx != state) ? '0 : tmr + 1'b1;
      word_cnt <= (state == REQ && tx_busy) ? word_cnt + 16'd1 : word_cnt;
      err_cnt  <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      ovf_flag <= (ovf_flag & {NUM_CH{~ovf_clr}}) | ovf;
    end
endmodule

// File: tb/tb_relay_1553.sv
// tb_relay_1553: randomized and directed checks of relay_1553 against a queue-based reference model
module tb_relay_1553;
  localparam int NCH = 2, DEPTH = 8, GAP = 8, TO = 64;
  localparam int GAP_LEN = GAP > 0 ? GAP : 1;
  logic          clk = 1'b0, reset_n = 1'b0;
  logic [NCH-1:0] ch_enable = '1, rx_dval = '0, rx_csw = '0, rx_dw = '0, rx_perr = '0;
  logic          drop_perr = 1'b0, tx_busy = 1'b0, ovf_clr = 1'b0;
  logic [16*NCH-1:0] rx_dword = '0;
  logic [15:0]   tx_dword, word_cnt;
  logic          tx_csw, tx_dw;
  logic [0:0]    tx_ch;
  logic [NCH-1:0] ovf_flag;
  logic [7:0]    err_cnt;
  always #5 clk = ~clk;
  relay_1553 #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .REQ_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .drop_perr(drop_perr),
    .rx_dval(rx_dval), .rx_csw(rx_csw), .rx_dw(rx_dw), .rx_perr(rx_perr), .rx_dword(rx_dword),
    .tx_busy(tx_busy), .tx_dword(tx_dword), .tx_csw(tx_csw), .tx_dw(tx_dw), .tx_ch(tx_ch),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );
  int n_tests = 0, n_fail = 0;
  // Reference model: per-channel word lists plus the relay's transaction phase in cycle time.
  logic [17:0] mq [NCH][DEPTH];
  int          mcnt [NCH];
  int          m_mode, m_until, cyc;
  logic [15:0] e_dword;
  bit          e_csw, e_lvld;
  int          e_ch, e_last, e_rr, e_err, e_wc;
  logic [NCH-1:0] e_ovf;
  int          enc_mode, enc_hold, enc_hold_len;
  bit          prev_req;
  logic [15:0] sent[$], want[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    m_mode = 0; m_until = 0; e_dword = '0; e_csw = 0; e_lvld = 0;
    e_ch = 0; e_last = 0; e_rr = 0; e_err = 0; e_wc = 0; e_ovf = '0;
  endtask
  task automatic model_step();
    int g, nerr, mode0;
    bit gv;
    logic [NCH-1:0] nov;
    cyc++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    gv = 0; g = 0; nerr = 0; nov = '0; mode0 = m_mode;
    if (mode0 == 0) begin
      if (e_lvld && mcnt[e_last] > 0 && mq[e_last][0][16]) begin gv = 1; g = e_last; end
      for (int i = 0; i < NCH; i++)
        if (!gv && mcnt[(e_rr + i) % NCH] > 0) begin gv = 1; g = (e_rr + i) % NCH; end
    end
    if (gv) begin
      e_dword = mq[g][0][15:0]; e_csw = mq[g][0][17]; e_ch = g; e_last = g; e_lvld = 1;
      e_rr = (g + 1) % NCH;
      for (int i = 0; i < DEPTH - 1; i++) mq[g][i] = mq[g][i+1];
      mcnt[g]--;
      m_mode = 1; m_until = cyc + TO;
    end else if (mode0 == 1) begin
      if (tx_busy) begin m_mode = 2; e_wc = (e_wc + 1) % 65536; end
      else if (cyc == m_until) begin m_mode = 3; m_until = cyc + GAP_LEN; nerr++; end
    end else if (mode0 == 2) begin
      if (!tx_busy) begin m_mode = 3; m_until = cyc + GAP_LEN; end
    end else if (mode0 == 3 && cyc == m_until) m_mode = 0;
    for (int c = 0; c < NCH; c++)
      if (rx_dval[c] && ch_enable[c]) begin
        if (rx_csw[c] == rx_dw[c] || (rx_perr[c] && drop_perr)) nerr++;
        else if (mcnt[c] == DEPTH) begin nov[c] = 1'b1; nerr++; end
        else begin mq[c][mcnt[c]] = {rx_csw[c], rx_dw[c], rx_dword[16*c +: 16]}; mcnt[c]++; end
      end
    e_err = (e_err + nerr > 255) ? 255 : e_err + nerr;
    e_ovf = (ovf_clr ? '0 : e_ovf) | nov;
  endtask
  task automatic compare();
    chk("tx_csw", 32'(tx_csw), 32'(m_mode == 1 && e_csw));
    chk("tx_dw", 32'(tx_dw), 32'(m_mode == 1 && !e_csw));
    chk("tx_dword", 32'(tx_dword), 32'(e_dword));
    chk("tx_ch", 32'(tx_ch), 32'(e_ch));
    chk("ovf_flag", 32'(ovf_flag), 32'(e_ovf));
    chk("err_cnt", 32'(err_cnt), 32'(e_err));
    chk("word_cnt", 32'(word_cnt), 32'(e_wc));
    if ((tx_csw | tx_dw) && !prev_req) sent.push_back(tx_dword);
    prev_req = tx_csw | tx_dw;
  endtask
  // Encoder stand-in: 0 random, 1 prompt with fixed hold, 2 never busy, 3 stuck busy.
  task automatic drive_enc();
    if (enc_mode == 3) tx_busy = 1'b1;
    else if (enc_mode == 2) tx_busy = 1'b0;
    else if (tx_busy) begin
      if (enc_hold == 0) tx_busy = 1'b0;
      else enc_hold--;
    end else if ((tx_csw | tx_dw) && (enc_mode == 1 || $urandom_range(0, 2) == 0)) begin
      tx_busy = 1'b1;
      enc_hold = enc_mode == 1 ? enc_hold_len : $urandom_range(0, 4);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    drive_enc();
    rx_dval = '0; rx_perr = '0; ovf_clr = 1'b0;
  endtask
  task automatic put(int c, bit csw, bit dw, logic [15:0] w, bit perr);
    rx_dval[c] = 1'b1; rx_csw[c] = csw; rx_dw[c] = dw; rx_perr[c] = perr;
    rx_dword[16*c +: 16] = w;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    prev_req = 0; sent.delete();
    rx_dval = '0; ovf_clr = 1'b0; tx_busy = 1'b0; enc_hold = 0;
    ch_enable = '1; drop_perr = 1'b0;
    #1;
    chk("rst_req", 32'(tx_csw | tx_dw), 0);
    chk("rst_dword", 32'(tx_dword), 0);
    chk("rst_ch", 32'(tx_ch), 0);
    chk("rst_ovf", 32'(ovf_flag), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_wc", 32'(word_cnt), 0);
    repeat (3) tick();
    reset_n = 1'b1;
  endtask
  task automatic chk_seq(string name);
    chk({name, "_len"}, 32'(sent.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < sent.size(); i++) chk(name, 32'(sent[i]), 32'(want[i]));
  endtask
  initial begin
    int r, cnt;
    cyc = 0; enc_mode = 1; enc_hold = 0; enc_hold_len = 2;
    @(negedge clk);
    do_reset();
    // Single CSW: request two cycles after the capture pulse.
    enc_mode = 1; enc_hold_len = 39;
    put(0, 1, 0, 16'h0C21, 0);
    tick();
    chk("t1_n1_req", 32'(tx_csw), 0);
    tick();
    chk("t1_n2_csw", 32'(tx_csw), 1);
    chk("t1_dword", 32'(tx_dword), 32'h0C21);
    chk("t1_ch", 32'(tx_ch), 0);
    repeat (50) tick();
    chk("t1_wc", 32'(word_cnt), 1);
    chk("t1_err", 32'(err_cnt), 0);
    // Message lock: ch0 CSW+3 DW stays together ahead of a queued ch1 CSW.
    do_reset();
    enc_mode = 1; enc_hold_len = 2;
    put(0, 1, 0, 16'hA001, 0); tick();
    put(0, 0, 1, 16'hD001, 0); put(1, 1, 0, 16'hB001, 0); tick();
    put(0, 0, 1, 16'hD002, 0); tick();
    put(0, 0, 1, 16'hD003, 0); tick();
    repeat (120) tick();
    want.delete();
    want.push_back(16'hA001); want.push_back(16'hD001); want.push_back(16'hD002);
    want.push_back(16'hD003); want.push_back(16'hB001);
    chk_seq("t2_order");
    // Overflow with the encoder stuck busy, then drain in order.
    do_reset();
    enc_mode = 3;
    put(0, 1, 0, 16'h0001, 0);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin put(1, 1, 0, 16'h1100 + 16'(i), 0); tick(); end
    tick();
    chk("t3_ovf", 32'(ovf_flag), 32'h2);
    chk("t3_err", 32'(err_cnt), 2);
    ovf_clr = 1'b1; tick();
    chk("t3_ovf_clr", 32'(ovf_flag), 0);
    enc_mode = 1; enc_hold_len = 1; tx_busy = 1'b0; sent.delete();
    repeat (200) tick();
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(16'h1100 + 16'(i));
    chk_seq("t3_drain");
    chk("t3_wc", 32'(word_cnt), 9);
    // Illegal kind and dropped parity error are not queued.
    do_reset();
    enc_mode = 1; drop_perr = 1'b1;
    put(0, 1, 1, 16'hEEEE, 0); put(1, 1, 0, 16'hFFFF, 1); tick();
    repeat (10) tick();
    chk("t4_err", 32'(err_cnt), 2);
    chk("t4_none", 32'(sent.size()), 0);
    // Request timeout, then the next word goes out.
    do_reset();
    enc_mode = 2;
    put(0, 1, 0, 16'h5555, 0); tick();
    put(0, 1, 0, 16'h6666, 0); tick();
    cnt = 0;
    while (tx_csw && cnt < 200) begin cnt++; tick(); end
    chk("t5_req_len", 32'(cnt), 64);
    chk("t5_err", 32'(err_cnt), 1);
    enc_mode = 1; enc_hold_len = 2;
    repeat (40) tick();
    chk("t5_next", 32'(sent.size() == 2 ? sent[1] : 16'h0), 32'h6666);
    chk("t5_wc", 32'(word_cnt), 1);
    // Reset during BUSY leaves nothing behind.
    do_reset();
    enc_mode = 3;
    put(0, 1, 0, 16'h7777, 0);
    repeat (5) tick();
    put(1, 1, 0, 16'h8888, 0); tick();
    chk("t6_wc_pre", 32'(word_cnt), 1);
    enc_mode = 1;
    do_reset();
    repeat (30) tick();
    chk("t6_nostale", 32'(sent.size()), 0);
    chk("t6_wc", 32'(word_cnt), 0);
    // Randomized traffic.
    enc_mode = 0;
    for (int t = 0; t < 4000; t++) begin
      if (t % 400 == 0) begin
        r = $urandom_range(0, 5);
        enc_mode = r == 0 ? 2 : (r == 1 ? 1 : 0);
        enc_hold_len = $urandom_range(0, 3);
      end
      if (t % 500 == 250) drop_perr = 1'($urandom_range(0, 1));
      if (t % 300 == 150) ch_enable = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b11;
      if (t == 2000) do_reset();
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 15);
          rx_dval[c] = 1'b1;
          rx_csw[c] = r == 0 || (r >= 2 && r < 7);
          rx_dw[c] = r == 0 || r >= 7;
          rx_perr[c] = $urandom_range(0, 9) == 0;
        end
      rx_dword = $urandom;
      ovf_clr = $urandom_range(0, 49) == 0;
      tick();
    end
    // err_cnt saturation.
    ch_enable = '1; enc_mode = 0;
    for (int t = 0; t < 200; t++) begin
      rx_dval = '1; rx_csw = '0; rx_dw = '0;
      tick();
    end
    chk("sat_err", 32'(err_cnt), 255);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
